// File: rtl/centimos_pkg.sv
// ============================================================================
// Module   : centimos_pkg
// Brief    : Shared constants and types for the cents-to-euros converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package centimos_pkg;

    localparam int CENTS_W        = 10;
    localparam int CENTS_PER_EURO = 100;
    localparam int CNT_W          = $clog2(CENTS_W + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    // Partial remainder must hold values up to 2*divisor-1 before the subtract.
    function automatic int rem_width(input int divisor);
        return $clog2(divisor) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/centimos_bcd2.sv
// ============================================================================
// Module   : centimos_bcd2
// Brief    : Two-digit binary-to-BCD converter for remainders 0..99.
// Revision : 1.0
// ============================================================================
`default_nettype none

module centimos_bcd2
    import centimos_pkg::*;
(
    input  logic [6:0] bin,
    output logic [7:0] bcd
);

    logic [3:0] w_tens;
    logic [3:0] w_units;

    always_comb begin
        w_tens  = 4'(bin / 7'd10);
        w_units = 4'(bin % 7'd10);
        bcd     = {w_tens, w_units};
    end

endmodule

`default_nettype wire

// File: rtl/centimos_pa_euros.sv
// ============================================================================
// Module   : centimos_pa_euros
// Brief    : Sequential restoring divider converting cents into euros and
//            remaining cents. Optional BCD remainder output: CENTIMOS_BCD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module centimos_pa_euros
    import centimos_pkg::*;
#(
    parameter int DIVISOR = CENTS_PER_EURO,
    parameter int W       = CENTS_W
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] centimos,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] eurosinteiros,
`ifdef CENTIMOS_BCD_EN
    output logic [7:0]   fracao_bcd,
`endif
    output logic [W-1:0] eurosfracao
);

    localparam int                 c_rem_w    = rem_width(DIVISOR);
    localparam int                 c_cnt_w    = $clog2(W + 1);
    localparam logic [c_rem_w:0]   c_div      = (c_rem_w + 1)'(DIVISOR);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(W);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_step;
    logic                 w_last;

    logic [W-1:0]         r_dividend;
    logic [W-1:0]         r_quot;
    logic [c_rem_w-1:0]   r_rem;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_done;

    logic [c_rem_w:0]     w_rem_shift;
    logic                 w_ge;
    logic [c_rem_w-1:0]   w_rem_next;
    logic [W-1:0]         w_quot_next;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = DIV;
            DIV:     if (r_cnt == c_cnt_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_accept = (r_state == IDLE) && start;
        w_step   = (r_state == DIV);
        w_last   = (r_state == DIV) && (r_cnt == c_cnt_last);
    end

    // ------------------------------------------------------------------
    // One restoring step per cycle, quotient MSB first
    // ------------------------------------------------------------------
    always_comb begin
        w_rem_shift = {r_rem, r_dividend[W-1]};
        w_ge        = (w_rem_shift >= c_div);
        w_rem_next  = w_ge ? c_rem_w'(w_rem_shift - c_div) : c_rem_w'(w_rem_shift);
        w_quot_next = (r_quot << 1) | W'(w_ge);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_dividend <= centimos;
                r_quot     <= '0;
                r_rem      <= '0;
                r_cnt      <= c_cnt_init;
            end else if (w_step) begin
                r_dividend <= r_dividend << 1;
                r_quot     <= w_quot_next;
                r_rem      <= w_rem_next;
                r_cnt      <= r_cnt - c_cnt_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers: written only on the final iteration edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eurosinteiros <= '0;
            eurosfracao   <= '0;
        end else if (w_last) begin
            eurosinteiros <= w_quot_next;
            eurosfracao   <= W'(w_rem_next);
        end
    end

`ifdef CENTIMOS_BCD_EN
    logic [7:0] w_bcd;

    centimos_bcd2 u_bcd2 (
        .bin (7'(w_rem_next)),
        .bcd (w_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fracao_bcd <= 8'h00;
        end else if (w_last) begin
            fracao_bcd <= w_bcd;
        end
    end
`endif

    assign busy = (r_state == DIV);
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_centimos_pa_euros.sv
// ============================================================================
// Module   : tb_centimos_pa_euros
// Brief    : Scoreboard bench for centimos_pa_euros with a /100, %100 model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_centimos_pa_euros;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] centimos;
    logic       busy;
    logic       done;
    logic [9:0] eurosinteiros;
    logic [9:0] eurosfracao;
`ifdef CENTIMOS_BCD_EN
    logic [7:0] fracao_bcd;
`endif

    centimos_pa_euros dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .centimos      (centimos),
        .busy          (busy),
        .done          (done),
        .eurosinteiros (eurosinteiros),
`ifdef CENTIMOS_BCD_EN
        .fracao_bcd    (fracao_bcd),
`endif
        .eurosfracao   (eurosfracao)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse retires exactly one expected result.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            chk("done_width", int'(prev_done), 0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("quotient", int'(eurosinteiros), e.q);
                chk("remainder", int'(eurosfracao), e.r);
`ifdef CENTIMOS_BCD_EN
                chk("bcd", int'(fracao_bcd), (e.r / 10) * 16 + (e.r % 10));
`endif
            end
        end
        prev_done = done;
    end

    // Called at a falling edge; returns at the falling edge after completion
    // so the next call can start back-to-back on the done cycle.
    task automatic convert(input int val, input int inject_at, input int abort_at);
        int         n;
        int         guard;
        logic [9:0] sq;
        logic [9:0] sr;
        bit         held;
        exp_t       e;
        guard = 0;
        while (busy && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            chk("idle_timeout", 1, 0);
            return;
        end
        sq       = eurosinteiros;
        sr       = eurosfracao;
        start    = 1'b1;
        centimos = val[9:0];
        e.q      = val / 100;
        e.r      = val % 100;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        centimos = 10'($urandom_range(0, 1023));
        n        = 0;
        held     = 1'b1;
        while (busy && n < 30) begin
            n++;
            if (eurosinteiros !== sq || eurosfracao !== sr) held = 1'b0;
            if (n == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_quotient", int'(eurosinteiros), 0);
                chk("abort_remainder", int'(eurosfracao), 0);
                void'(sb.pop_back());
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (n == inject_at) begin
                start    = 1'b1;
                centimos = 10'd555;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_cycles", n, 10);
        chk("held_while_busy", int'(held), 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        centimos = '0;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_quotient", int'(eurosinteiros), 0);
        chk("reset_remainder", int'(eurosfracao), 0);
`ifdef CENTIMOS_BCD_EN
        chk("reset_bcd", int'(fracao_bcd), 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        convert(470, 0, 0);
        convert(0, 0, 0);
        convert(99, 0, 0);
        convert(100, 0, 0);
        convert(1023, 0, 0);
        convert(777, 4, 0);
        convert(470, 0, 5);
        convert(250, 0, 0);
        for (int i = 0; i < 40; i++) begin
            convert(int'($urandom_range(0, 1023)), 0, 0);
        end
        convert(1023, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/centimos_pa_euros.md
Name: centimos_pa_euros

Overview:
- Converts an amount in cents (0..1023) into whole euros and the remaining cents.
- Used in the scale (Balanca) price path before display formatting.
- Implemented as a sequential restoring divider by the constant 100, with a start/busy/done handshake and registered outputs.

Parameters:
- DIVISOR, 100, constant divisor (cents per euro). Must be greater than 0 and less than 1024.
- W, 10, width of the input and both outputs.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request a conversion. Sampled only while idle.
- centimos  input  W  amount in cents. Captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new results are written.
- eurosinteiros  output  W  centimos / DIVISOR (quotient), zero-extended.
- eurosfracao  output  W  centimos % DIVISOR (remainder), zero-extended.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - busy=0, done=0.
  - eurosinteiros=0, eurosfracao=0.
  - Internal quotient, remainder, dividend and bit counter are cleared.
  - Any conversion in progress is aborted with no done pulse.
- Accept edge E0: start=1 and busy=0.
  - centimos is latched into the dividend register.
  - Partial remainder is cleared and the counter is set to W.
  - busy=1 from E0.
  - start with busy=1 is ignored; no queuing.
- Iteration edges E1..E10 (one quotient bit per cycle, MSB first):
  - rem = {rem, dividend[msb]}.
  - If rem >= DIVISOR, subtract DIVISOR and set the quotient bit to 1; otherwise the bit is 0.
  - The dividend shifts left by one.
- Completion at E10:
  - eurosinteiros and eurosfracao are loaded with the final quotient and remainder.
  - busy falls to 0.
  - done=1 for exactly one cycle.
- Latency: results are visible 10 cycles after the accept edge.
- A new start may be accepted on the cycle where done=1; back-to-back throughput is one conversion per 11 cycles.
- Outputs hold their last result between conversions and do not change while busy.
- Ranges:
  - Quotient 0..10 with DIVISOR=100 (1023 gives 10). Bits above the quotient range are 0.
  - Remainder 0..DIVISOR-1. Bits 9:7 are always 0.
- Partial remainder register is 8 bits wide (ceil(log2(DIVISOR))+1) and must never overflow.
- centimos may change after E0 without affecting the result.

Optional Feature:
- Macro: CENTIMOS_BCD_EN.
- Defined:
  - Adds output fracao_bcd (8 bits). Upper nibble = tens digit of eurosfracao, lower nibble = units digit.
  - Registered and updated at the same edge as eurosfracao.
  - Reset value 0.
  - Example: a remainder of 70 gives 8'h70.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package centimos_pkg holds:
  - CENTS_W = 10.
  - CENTS_PER_EURO = 100.
  - Counter width constant.
  - State typedef {IDLE, DIV}.
- One natural sub-module: centimos_bcd2, a small remainder-to-BCD converter (two digits, 0..99). It is instantiated only under CENTIMOS_BCD_EN.

Test Plan:
- centimos=470 with start -> done after 10 cycles; eurosinteiros=4, eurosfracao=70 (fracao_bcd=8'h70 when enabled).
- centimos=0, then 99, then 100 -> results (0,0), (0,99), (1,0). done is exactly one cycle wide each time.
- centimos=1023 -> (10,23). Outputs unchanged while busy; busy high for exactly 10 cycles.
- start pulsed again mid-conversion with centimos=555 -> ignored; the first result completes; no extra done pulse.
- rst_n driven low at iteration 5 of a conversion of 470 -> outputs=0 and busy=0 immediately (asynchronously); no done pulse. After release, a start with 250 gives (2,50).
- Randomized sweep of 0..1023 against a reference model of /100 and %100.
